dbus_sram_responder: RTL and testbench
======================================

DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 64-bit words held (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 SHALL have port dreq  input  dbus_req_t  request from the core (valid, addr, size, strobe, data).
REQ-006 SHALL have port dresp  output  dbus_resp_t  response to the core (addr_ok, data_ok, data).
REQ-007 SHALL have port busy  output  1  high while a request is outstanding (WAIT or RESP).

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-009 In IDLE with dreq.valid high, SHALL accept the request: latch addr, strobe and data, and load the latency counter.
REQ-010 SHALL go from IDLE to RESP when LATENCY==1, else to WAIT; WAIT SHALL last exactly LATENCY-1 cycles.
REQ-011 In RESP, for exactly one cycle, SHALL assert dresp.addr_ok and dresp.data_ok together, then return to IDLE.
REQ-012 dresp.data in RESP SHALL be the full 64-bit word at index addr[3 +: log2(DEPTH)], taken before any write in that cycle.
REQ-013 On the RESP clock edge, SHALL write byte i of the latched data to the indexed word for each set strobe bit i; strobe==0 SHALL mean a read with no write.
REQ-014 Address bits above the index and bits [2:0] SHALL be ignored; out-of-range addresses wrap modulo DEPTH.
REQ-015 dreq.size SHALL be ignored; the core extracts and aligns sub-word data.
REQ-016 A new request SHALL NOT be accepted in the RESP cycle; earliest acceptance is the cycle after RESP, giving a throughput of one request per LATENCY+1 cycles.
REQ-017 If dreq.valid drops in WAIT or RESP (protocol violation), SHALL return to IDLE next cycle with no write and no data_ok.
REQ-018 Changes to dreq fields after acceptance SHALL be ignored; the latched copies are used.
REQ-019 Outside RESP, dresp.addr_ok, dresp.data_ok and dresp.data SHALL be 0.
REQ-020 busy SHALL be high exactly in WAIT and RESP.

Reset
REQ-021 reset high SHALL force IDLE, clear the counter and latches, and drive dresp='0 and busy=0 in the next cycle, including mid-transaction.
REQ-022 A write pending at reset SHALL be dropped; memory contents SHALL NOT be cleared by reset.

Structure
REQ-023 dbus_req_t, dbus_resp_t, msize_t and strobe width SHALL come from the shared common package; a new constant DBUS_RESP_LATENCY_DEFAULT=2 SHALL be added there.
REQ-024 The storage SHALL be one sub-module sram_bytewrite (single port, asynchronous read, per-byte write enable, no reset), parameterised by DEPTH.
REQ-025 FSM, counter and latches SHALL live in dbus_sram_responder; the target size is 120-400 RTL lines total.

Verification
REQ-026 Write then read: store addr 0x80, data 0x1122334455667788, strobe 0xFF, LATENCY=2 -> data_ok 2 cycles after acceptance; following load at 0x80 returns 0x1122334455667788.
REQ-027 Byte strobe: word 0x0 is all ones; store data 0xAB00 strobe 0x02 -> read returns 0xFFFFFFFFFFFFABFF.
REQ-028 Latency sweep: LATENCY=1 -> data_ok the cycle after acceptance; LATENCY=4 -> data_ok 4 cycles after; busy high for exactly LATENCY cycles; back-to-back valid accepted every LATENCY+1 cycles.
REQ-029 Wrap: DEPTH=1024, store at addr 0x2000 -> load at 0x0 returns the stored value; load at 0x2005 returns the same word.
REQ-030 Reset mid-op: assert reset in WAIT of a store to 0x40 -> no data_ok, busy=0, dresp=0 the next cycle; word 0x40 unchanged.
REQ-031 Protocol violation: drop valid in WAIT -> IDLE next cycle, no write; the next valid request completes normally.

Source files
------------

// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and constants for the SRAM responder.
// Exports dbus_req_t, dbus_resp_t, msize_t, strobe width, FSM state type.
package dbus_sram_responder_pkg;

  localparam int unsigned DBUS_ADDR_W = 32;
  localparam int unsigned DBUS_DATA_W = 64;
  localparam int unsigned DBUS_STRB_W = DBUS_DATA_W / 8;
  localparam int unsigned DBUS_RESP_LATENCY_DEFAULT = 2;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [DBUS_STRB_W-1:0] strobe_t;

  typedef struct packed {
    logic                   valid;
    logic [DBUS_ADDR_W-1:0] addr;
    msize_t                 size;
    strobe_t                strobe;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_state_e;

endpackage

// File: rtl/dbus_sram_responder_sram.sv
// Single-port 64-bit word store, async read, per-byte write enable.
// Ports: clk_i, we_i (byte enables), addr_i (word index), wdata_i, rdata_o.
module sram_bytewrite
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                         clk_i,
  input  logic [DBUS_STRB_W-1:0]       we_i,
  input  logic [$clog2(DEPTH)-1:0]     addr_i,
  input  logic [DBUS_DATA_W-1:0]       wdata_i,
  output logic [DBUS_DATA_W-1:0]       rdata_o
);

  logic [DBUS_DATA_W-1:0] mem_q [DEPTH];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DBUS_STRB_W; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: accepts one request, answers after LATENCY.
// Ports: clk, reset (sync, active high), dreq in, dresp out, busy out.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = DBUS_RESP_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int unsigned IW = $clog2(DEPTH);

  dbus_state_e            state_q;
  logic [3:0]             cnt_q;
  logic [IW-1:0]          idx_q;
  strobe_t                strb_q;
  logic [DBUS_DATA_W-1:0] wdat_q;
  logic                   rok_q;
  logic                   busy_q;

  strobe_t                we_d;
  logic [DBUS_DATA_W-1:0] rdata;
  logic                   unused_ok;

  // Size and the non-index address bits are don't-care here.
  assign unused_ok = ^{dreq.size, dreq.addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      strb_q  <= '0;
      wdat_q  <= '0;
      rok_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rok_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            idx_q  <= dreq.addr[3 +: IW];
            strb_q <= dreq.strobe;
            wdat_q <= dreq.data;
            busy_q <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= RESP;
              rok_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (!dreq.valid) begin
            // Core abandoned the request: drop it.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd1) begin
            state_q <= RESP;
            rok_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write lands on the edge closing RESP; dropped on reset or lost valid.
  always_comb begin
    we_d = '0;
    if (state_q == RESP && dreq.valid && !reset) begin
      we_d = strb_q;
    end
  end

  sram_bytewrite #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (we_d),
    .addr_i  (idx_q),
    .wdata_i (wdat_q),
    .rdata_o (rdata)
  );

  // Async read shows the word as it was before this cycle's write.
  assign dresp.addr_ok = rok_q;
  assign dresp.data_ok = rok_q;
  assign dresp.data    = rok_q ? rdata : '0;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three latencies, random and directed.
// Reference memory is a plain array updated byte-wise per request.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq  [3];
  dbus_resp_t dresp [3];
  logic       busy  [3];

  int lat [3] = '{1, 2, 4};
  logic [63:0] mdl [3][1024];

  int errors = 0;
  int checks = 0;

  dbus_sram_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .dreq(dreq[0]),
    .dresp(dresp[0]), .busy(busy[0])
  );
  dbus_sram_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .dreq(dreq[1]),
    .dresp(dresp[1]), .busy(busy[1])
  );
  dbus_sram_responder #(.DEPTH(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .dreq(dreq[2]),
    .dresp(dresp[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, " busy"}, 64'(busy[k]), 64'(0));
    chk({tag, " data_ok"}, 64'(dresp[k].data_ok), 64'(0));
    chk({tag, " addr_ok"}, 64'(dresp[k].addr_ok), 64'(0));
    chk({tag, " data"}, dresp[k].data, 64'(0));
  endtask

  // Called at a negedge with DUT k idle; returns at the negedge
  // one cycle after RESP, so back-to-back calls test throughput.
  task automatic txn(input int k, input logic [31:0] a,
                     input logic [7:0] s, input logic [63:0] d,
                     input string tag, output logic [63:0] rd);
    int idx;
    logic [63:0] exp;
    idx = int'(a[12:3]);
    exp = mdl[k][idx];
    dreq[k].valid  = 1'b1;
    dreq[k].addr   = a;
    dreq[k].size   = msize_t'($urandom_range(0, 3));
    dreq[k].strobe = s;
    dreq[k].data   = d;
    chk({tag, " busy@acc"}, 64'(busy[k]), 64'(0));
    rd = '0;
    for (int c = 1; c <= lat[k]; c++) begin
      @(negedge clk);
      if (c == 1) begin
        dreq[k].addr   = $urandom;
        dreq[k].strobe = 8'($urandom);
        dreq[k].data   = {$urandom, $urandom};
      end
      chk({tag, " busy"}, 64'(busy[k]), 64'(1));
      chk({tag, " data_ok"}, 64'(dresp[k].data_ok),
          64'(c == lat[k]));
      chk({tag, " addr_ok"}, 64'(dresp[k].addr_ok),
          64'(c == lat[k]));
      if (c < lat[k]) begin
        chk({tag, " data@wait"}, dresp[k].data, 64'(0));
      end else begin
        rd = dresp[k].data;
        if (!$isunknown(exp)) chk({tag, " rdata"}, rd, exp);
      end
    end
    for (int b = 0; b < 8; b++) begin
      if (s[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
    end
    @(negedge clk);
    dreq[k].valid = 1'b0;
    chk_idle(k, {tag, " after"});
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] old;
    logic [31:0] a;
    logic [7:0]  s;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) dreq[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k, "reset");
    reset = 1'b0;

    // Fill a 32-word pool per DUT, via wrapping addresses.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) begin
        a = $urandom;
        a[12:3] = 10'(i);
        txn(k, a, 8'hFF, {$urandom, $urandom}, "init", rd);
      end
    end

    // Write then read at 0x80.
    txn(1, 32'h80, 8'hFF, 64'h1122334455667788, "st80", rd);
    txn(1, 32'h80, 8'h00, 64'h0, "ld80", rd);
    chk("ld80 value", rd, 64'h1122334455667788);

    // Byte strobe into an all-ones word.
    txn(1, 32'h0, 8'hFF, '1, "ones", rd);
    txn(1, 32'h0, 8'h02, 64'hAB00, "strb", rd);
    txn(1, 32'h0, 8'h00, 64'h0, "ldstrb", rd);
    chk("strobe value", rd, 64'hFFFFFFFFFFFFABFF);

    // Wrap modulo DEPTH.
    txn(1, 32'h2000, 8'hFF, 64'hCAFEF00D12345678, "wrap st", rd);
    txn(1, 32'h0, 8'h00, 64'h0, "wrap ld0", rd);
    chk("wrap 0x0", rd, 64'hCAFEF00D12345678);
    txn(1, 32'h2005, 8'h00, 64'h0, "wrap ld2005", rd);
    chk("wrap 0x2005", rd, 64'hCAFEF00D12345678);

    // Reset during WAIT of a store to 0x40.
    old = mdl[1][8];
    dreq[1] = '{valid: 1'b1, addr: 32'h40, size: MSIZE8,
                strobe: 8'hFF, data: ~old};
    @(negedge clk);
    chk("rstw busy", 64'(busy[1]), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk_idle(1, "rstw");
    reset = 1'b0;
    dreq[1].valid = 1'b0;
    @(negedge clk);
    txn(1, 32'h40, 8'h00, 64'h0, "rstw ld", rd);
    chk("rstw kept", rd, old);

    // Reset during RESP drops the pending write.
    old = mdl[1][10];
    dreq[1] = '{valid: 1'b1, addr: 32'h50, size: MSIZE8,
                strobe: 8'hFF, data: ~old};
    @(negedge clk);
    @(negedge clk);
    chk("rstr data_ok", 64'(dresp[1].data_ok), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk_idle(1, "rstr");
    reset = 1'b0;
    dreq[1].valid = 1'b0;
    @(negedge clk);
    txn(1, 32'h50, 8'h00, 64'h0, "rstr ld", rd);
    chk("rstr kept", rd, old);

    // Valid dropped in WAIT: abort, then a normal request.
    old = mdl[1][9];
    dreq[1] = '{valid: 1'b1, addr: 32'h48, size: MSIZE8,
                strobe: 8'hFF, data: ~old};
    @(negedge clk);
    chk("drop busy", 64'(busy[1]), 64'(1));
    dreq[1].valid = 1'b0;
    @(negedge clk);
    chk_idle(1, "drop");
    txn(1, 32'h48, 8'h00, 64'h0, "drop ld", rd);
    chk("drop kept", rd, old);

    // Random back-to-back traffic on every latency.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        a = $urandom;
        a[12:3] = 10'($urandom_range(0, 31));
        s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        txn(k, a, s, {$urandom, $urandom}, "rand", rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
